// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared encodings for the decoder scan family: FSM states, scan modes and
// the first select code of a sweep.
package decoder_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } scan_state_e;

  typedef enum logic [1:0] {
    MODE_CONT_UP   = 2'b00,
    MODE_CONT_DOWN = 2'b01,
    MODE_SINGLE_UP = 2'b10,
    MODE_RSVD      = 2'b11
  } scan_mode_e;

  localparam logic [1:0] SEL_LO = 2'b00;
  localparam logic [1:0] SEL_HI = 2'b11;

  // Reserved mode scans like continuous up, so only down starts high.
  function automatic logic [1:0] first_sel(input scan_mode_e m);
    logic [1:0] s;
    case (m)
      MODE_CONT_DOWN: s = SEL_HI;
      MODE_CONT_UP,
      MODE_SINGLE_UP,
      MODE_RSVD:      s = SEL_LO;
      default:        s = SEL_LO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl_dwell_timer.sv
// Dwell timer: counts 0..dwell while enabled and flags expiry on the last
// count; load (or reset) restarts it at 0.
module dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_r;

  assign expire = en && (cnt_r == dwell);

  // Dwell counter, wraps to 0 on expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {DWELL_W{1'b0}};
    end else if (load) begin
      cnt_r <= {DWELL_W{1'b0}};
    end else if (en) begin
      if (cnt_r == dwell) cnt_r <= {DWELL_W{1'b0}};
      else                cnt_r <= cnt_r + {{(DWELL_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller stepping a 2-to-4 decoder select through its addresses,
// with per-address dwell, continuous/single sweeps and a deferred stop.
import decoder_scan_ctrl_pkg::*;

module decoder_scan_ctrl #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   sweep_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  scan_state_e        state_r;
  scan_mode_e         mode_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               stop_pend_r;
  logic [1:0]         sel_r;
  logic               sel_valid_r;
  logic               busy_r;
  logic               done_r;
  logic [CNT_W-1:0]   sweep_cnt_r;

  logic               tmr_en_s;
  logic               tmr_load_s;
  logic               expire_s;
  logic               down_s;
  logic               at_end_s;
  logic               single_s;
  logic               stop_eff_s;
  logic [1:0]         next_sel_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  assign sel       = sel_r;
  assign sel_valid = sel_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign sweep_cnt = sweep_cnt_r;

  assign tmr_en_s   = (state_r == ST_RUN);
  assign tmr_load_s = (state_r != ST_RUN);

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load_s),
    .en     (tmr_en_s),
    .dwell  (dwell_r),
    .expire (expire_s)
  );

  // Sweep direction, end-of-sweep detection and saturating counter increment.
  always_comb begin
    down_s     = (mode_r == MODE_CONT_DOWN);
    single_s   = (mode_r == MODE_SINGLE_UP);
    stop_eff_s = stop_pend_r || stop;
    if (down_s) begin
      at_end_s   = (sel_r == SEL_LO);
      next_sel_s = sel_r - 2'b01;
    end else begin
      at_end_s   = (sel_r == SEL_HI);
      next_sel_s = sel_r + 2'b01;
    end
    if (sweep_cnt_r == CNT_MAX) cnt_inc_s = sweep_cnt_r;
    else                        cnt_inc_s = sweep_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Scan FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_CONT_UP;
      dwell_r     <= {DWELL_W{1'b0}};
      stop_pend_r <= 1'b0;
      sel_r       <= SEL_LO;
      sel_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sweep_cnt_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          stop_pend_r <= 1'b0;
          done_r      <= 1'b0;
          if (start && !stop) begin
            state_r     <= ST_RUN;
            mode_r      <= scan_mode_e'(mode);
            dwell_r     <= dwell;
            sel_r       <= first_sel(scan_mode_e'(mode));
            sel_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            sweep_cnt_r <= {CNT_W{1'b0}};
          end else begin
            sel_r       <= SEL_LO;
            sel_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (expire_s) begin
            // A single sweep ending together with a stop yields one DONE entry.
            if ((single_s && at_end_s) || stop_eff_s) begin
              state_r     <= ST_DONE;
              done_r      <= 1'b1;
              sel_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              stop_pend_r <= 1'b0;
              if (single_s && at_end_s) sweep_cnt_r <= cnt_inc_s;
              else                      sweep_cnt_r <= sweep_cnt_r;
            end else begin
              sel_r <= next_sel_s;
              if (at_end_s) sweep_cnt_r <= cnt_inc_s;
              else          sweep_cnt_r <= sweep_cnt_r;
            end
          end else if (stop) begin
            stop_pend_r <= 1'b1;
          end else begin
            stop_pend_r <= stop_pend_r;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          sel_r       <= SEL_LO;
          sel_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          stop_pend_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          sel_r       <= SEL_LO;
          sel_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          stop_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed self-checking bench for decoder_scan_ctrl (CNT_W=2 so that
// saturation is reachable quickly).
module tb_decoder_scan_ctrl;

  localparam int DWELL_W = 8;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         sel;
  logic               sel_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   sweep_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.DWELL_W(DWELL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .sel       (sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done),
    .sweep_cnt (sweep_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input int exp_cnt);
    check_eq({tag, ".sel"}, 32'(sel), 32'd0);
    check_eq({tag, ".valid"}, 32'(sel_valid), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".cnt"}, 32'(sweep_cnt), 32'(exp_cnt));
  endtask

  task automatic check_done(input string tag, input int exp_cnt);
    check_eq({tag, ".done"}, 32'(done), 32'd1);
    check_eq({tag, ".valid"}, 32'(sel_valid), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".cnt"}, 32'(sweep_cnt), 32'(exp_cnt));
  endtask

  task automatic launch(input logic [1:0] m, input logic [DWELL_W-1:0] d);
    mode  = m;
    dwell = d;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00; dwell = 8'd0;
    tick();
    tick();
    check_idle("reset", 0);
    rst_n = 1'b1;
    tick();
    check_idle("idle_hold", 0);

    // start together with stop in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check_idle("start_stop", 0);
    tick();
    check_idle("start_stop2", 0);

    // mode 00, dwell 2; input changes and a re-start while running are ignored
    launch(2'b00, 8'd2);
    mode = 2'b11; dwell = 8'd0;
    for (int k = 0; k <= 13; k++) begin
      check_eq($sformatf("up.sel[%0d]", k), 32'(sel), 32'((k / 3) % 4));
      check_eq($sformatf("up.valid[%0d]", k), 32'(sel_valid), 32'd1);
      check_eq($sformatf("up.busy[%0d]", k), 32'(busy), 32'd1);
      check_eq($sformatf("up.cnt[%0d]", k), 32'(sweep_cnt), (k >= 12) ? 32'd1 : 32'd0);
      start = (k == 5) ? 1'b1 : 1'b0;
      stop  = (k == 13) ? 1'b1 : 1'b0;
      tick();
    end
    stop = 1'b0;
    // pending stop waits for the end of the current dwell
    check_eq("up.stop_wait.sel", 32'(sel), 32'd0);
    check_eq("up.stop_wait.busy", 32'(busy), 32'd1);
    tick();
    check_done("up.done", 1);
    tick();
    check_idle("up.idle", 1);

    // mode 10, dwell 0: single sweep then one done pulse
    launch(2'b10, 8'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("single.sel[%0d]", k), 32'(sel), 32'(k));
      check_eq($sformatf("single.valid[%0d]", k), 32'(sel_valid), 32'd1);
      check_eq($sformatf("single.cnt[%0d]", k), 32'(sweep_cnt), 32'd0);
      tick();
    end
    check_done("single.done", 1);
    tick();
    check_idle("single.idle", 1);

    // mode 01, dwell 1, stop in the first cycle at sel=2
    launch(2'b01, 8'd1);
    check_eq("down.sel0", 32'(sel), 32'd3);
    check_eq("down.cnt_clear", 32'(sweep_cnt), 32'd0);
    tick();
    check_eq("down.sel1", 32'(sel), 32'd3);
    tick();
    check_eq("down.sel2", 32'(sel), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("down.sel3", 32'(sel), 32'd2);
    check_eq("down.valid3", 32'(sel_valid), 32'd1);
    tick();
    check_done("down.done", 0);
    check_eq("down.sel_held", 32'(sel), 32'd2);
    tick();
    check_idle("down.idle", 0);

    // CNT_W=2, mode 00, dwell 0: sweep count saturates at 3
    launch(2'b00, 8'd0);
    for (int k = 0; k <= 20; k++) begin
      check_eq($sformatf("sat.sel[%0d]", k), 32'(sel), 32'(k % 4));
      check_eq($sformatf("sat.cnt[%0d]", k), 32'(sweep_cnt), (k / 4 > 3) ? 32'd3 : 32'(k / 4));
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("sat.reset", 0);

    // reserved mode scans like continuous up
    launch(2'b11, 8'd0);
    for (int k = 0; k <= 4; k++) begin
      check_eq($sformatf("rsvd.sel[%0d]", k), 32'(sel), 32'(k % 4));
      tick();
    end
    check_eq("rsvd.cnt", 32'(sweep_cnt), 32'd1);

    // reset mid-dwell, then a fresh start restarts at sel=0 with a clean timer
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    launch(2'b01, 8'd3);
    tick();
    check_eq("mid.sel_before", 32'(sel), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("mid.reset", 0);
    tick();
    check_idle("mid.after", 0);
    launch(2'b00, 8'd3);
    for (int k = 0; k <= 4; k++) begin
      check_eq($sformatf("fresh.sel[%0d]", k), 32'(sel), (k >= 4) ? 32'd1 : 32'd0);
      check_eq($sformatf("fresh.valid[%0d]", k), 32'(sel_valid), 32'd1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;

    // stop coinciding with single-sweep end gives one DONE cycle
    launch(2'b10, 8'd0);
    tick(); tick(); tick();
    check_eq("coinc.sel3", 32'(sel), 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_done("coinc.done", 1);
    tick();
    check_idle("coinc.idle", 1);
    tick();
    check_idle("coinc.idle2", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
